// File: rtl/piso_nbit_tx.sv
// rtl/piso_nbit_tx.sv - parallel-in serial-out transmitter with valid/ready load
// Optional even-parity trailer bit when PISO_PARITY_EN is defined.
module piso_nbit_tx #(
    parameter int N         = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         reset_ah_in,
    input  logic         load_valid_in,
    output logic         load_ready_out,
    input  logic [N-1:0] data_in,
    output logic         q_out,
    output logic         q_valid_out,
    output logic         frame_start_out,
    output logic         busy_out
);

    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef PISO_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          q_q, q_d;
    logic          valid_q, valid_d;
    logic          start_q, start_d;
    logic          busy_q, busy_d;
`ifdef PISO_PARITY_EN
    logic          par_q, par_d;
`endif

    logic last_cycle;
    logic accept;
    logic first_bit;
    logic next_bit;

    // Ready is asserted in the final output cycle so the next frame follows with no gap.
`ifdef PISO_PARITY_EN
    assign last_cycle = (state_q == PARITY);
`else
    assign last_cycle = (state_q == SHIFT) && (cnt_q == LAST);
`endif

    assign load_ready_out = ~reset_ah_in & ((state_q == IDLE) | last_cycle);
    assign accept         = load_valid_in & load_ready_out;

    assign first_bit = MSB_FIRST ? data_in[N-1] : data_in[0];
    assign next_bit  = MSB_FIRST ? shift_q[N-1] : shift_q[0];

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        valid_d = valid_q;
        start_d = 1'b0;
        busy_d  = busy_q;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif
        if (accept) begin
            // The first bit goes straight to q; the shift register keeps the remainder.
            state_d = SHIFT;
            shift_d = MSB_FIRST ? (data_in << 1) : (data_in >> 1);
            cnt_d   = '0;
            q_d     = first_bit;
            valid_d = 1'b1;
            start_d = 1'b1;
            busy_d  = 1'b1;
`ifdef PISO_PARITY_EN
            par_d   = ^data_in;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
`ifdef PISO_PARITY_EN
                        state_d = PARITY;
                        q_d     = par_q;
`else
                        state_d = IDLE;
                        q_d     = 1'b0;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
`endif
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        q_d     = next_bit;
                        shift_d = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                    end
                end
`ifdef PISO_PARITY_EN
                PARITY: begin
                    state_d = IDLE;
                    q_d     = 1'b0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
`endif
                default: begin
                    q_d     = 1'b0;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset_ah_in) begin
        if (reset_ah_in) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            valid_q <= valid_d;
            start_q <= start_d;
            busy_q  <= busy_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign q_out           = q_q;
    assign q_valid_out     = valid_q;
    assign frame_start_out = start_q;
    assign busy_out        = busy_q;

endmodule

// File: tb/tb_piso_nbit_tx.sv
// tb/tb_piso_nbit_tx.sv - directed bench for piso_nbit_tx (LSB-first and MSB-first instances)
module tb_piso_nbit_tx;

`ifdef PISO_PARITY_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lv0 = 1'b0, lv1 = 1'b0;
    logic [3:0] d0 = 4'h0, d1 = 4'h0;
    logic       rdy0, q0, qv0, fs0, bsy0;
    logic       rdy1, q1, qv1, fs1, bsy1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    piso_nbit_tx #(.N(4), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .reset_ah_in(rst), .load_valid_in(lv0), .load_ready_out(rdy0),
        .data_in(d0), .q_out(q0), .q_valid_out(qv0), .frame_start_out(fs0), .busy_out(bsy0)
    );

    piso_nbit_tx #(.N(4), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .reset_ah_in(rst), .load_valid_in(lv1), .load_ready_out(rdy1),
        .data_in(d1), .q_out(q1), .q_valid_out(qv1), .frame_start_out(fs1), .busy_out(bsy1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // seq[i] is the i-th expected serial bit (parity bit in seq[4]).
    task automatic send_frame(input string tag, input bit sel, input logic [3:0] d,
                              input logic [4:0] seq);
        logic bq, bv, bs, bb;
        check({tag, "_ready_pre"}, sel ? rdy1 : rdy0, 1'b1);
        if (sel) begin lv1 = 1'b1; d1 = d; end
        else     begin lv0 = 1'b1; d0 = d; end
        @(posedge clk); #1;
        lv0 = 1'b0; lv1 = 1'b0;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            bq = sel ? q1 : q0;   bv = sel ? qv1 : qv0;
            bs = sel ? fs1 : fs0; bb = sel ? bsy1 : bsy0;
            check($sformatf("%s_q%0d", tag, i), bq, seq[i]);
            check($sformatf("%s_v%0d", tag, i), bv, 1'b1);
            check($sformatf("%s_fs%0d", tag, i), bs, (i == 0));
            check($sformatf("%s_busy%0d", tag, i), bb, 1'b1);
        end
        @(negedge clk);
        check({tag, "_v_end"}, sel ? qv1 : qv0, 1'b0);
        check({tag, "_busy_end"}, sel ? bsy1 : bsy0, 1'b0);
        check({tag, "_q_end"}, sel ? q1 : q0, 1'b0);
        check({tag, "_ready_end"}, sel ? rdy1 : rdy0, 1'b1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [4:0] seq_a, seq_b;

        // Reset state
        #20;
        check("rst_ready", rdy0, 1'b0);
        check("rst_valid", qv0, 1'b0);
        check("rst_busy", bsy0, 1'b0);
        check("rst_q", q0, 1'b0);
        check("rst_fs", fs0, 1'b0);
        #30 rst = 1'b0;
        @(posedge clk); #1;

        // 1: LSB first 1011 -> 1,1,0,1 (parity 1)
        send_frame("t1", 1'b0, 4'b1011, 5'b11011);
        // 2: MSB first 1011 -> 1,0,1,1 (parity 1)
        send_frame("t2", 1'b1, 4'b1011, 5'b11101);

        // 3: back-to-back A then 5 -> 0,1,0,1 | 1,0,1,0 (parities 0)
        seq_a = 5'b01010;
        seq_b = 5'b00101;
        lv0 = 1'b1; d0 = 4'hA;
        @(posedge clk); #1;
        d0 = 4'h5;
        for (int i = 0; i < 2 * FL; i++) begin
            @(negedge clk);
            check($sformatf("t3_q%0d", i), q0, (i < FL) ? seq_a[i] : seq_b[i - FL]);
            check($sformatf("t3_v%0d", i), qv0, 1'b1);
            check($sformatf("t3_fs%0d", i), fs0, (i == 0) || (i == FL));
            if (i == FL - 1) check("t3_ready_last", rdy0, 1'b1);
            if (i == 1) check("t3_ready_mid", rdy0, 1'b0);
            if (i == FL) lv0 = 1'b0;
        end
        @(negedge clk);
        check("t3_v_end", qv0, 1'b0);
        @(posedge clk); #1;

        // 4: reset during third bit of F
        lv0 = 1'b1; d0 = 4'hF;
        @(posedge clk); #1;
        lv0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t4_q%0d", i), q0, 1'b1);
        end
        rst = 1'b1;
        #1;
        check("t4_v_rst", qv0, 1'b0);
        check("t4_busy_rst", bsy0, 1'b0);
        check("t4_ready_rst", rdy0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t4_v_after", qv0, 1'b0);
        @(posedge clk); #1;
        send_frame("t4b", 1'b0, 4'h3, 5'b00011);

        // 5: pulse valid while busy, change data mid-frame; 6 -> 0,1,1,0
        lv0 = 1'b1; d0 = 4'h6;
        @(posedge clk); #1;
        lv0 = 1'b0;
        seq_a = 5'b00110;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            check($sformatf("t5_q%0d", i), q0, seq_a[i]);
            check($sformatf("t5_fs%0d", i), fs0, (i == 0));
            if (i == 1) begin lv0 = 1'b1; d0 = 4'h9; end
            if (i == 2) lv0 = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t5_idle_v%0d", i), qv0, 1'b0);
            check($sformatf("t5_idle_b%0d", i), bsy0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
